// File: rtl/vga_scope_display.sv
// vga_scope_display: double-buffered oscilloscope trace renderer with graticule, axes and border.
// Two-stage pipeline: stage 1 registers coordinates, sample row and grid phase; stage 2 registers the colour.
module vga_scope_display #(
    parameter int H_DISP   = 1280,
    parameter int V_DISP   = 720,
    parameter int WIN_X0   = 139,
    parameter int WIN_X1   = 1140,
    parameter int WIN_Y0   = 48,
    parameter int WIN_Y1   = 624,
    parameter int GRID_X   = 64,
    parameter int GRID_Y   = 32,
    parameter int CW       = 2,
    parameter int SAMPLE_W = 10,
    parameter int AW       = 10
) (
    input  logic                pixel_clk,
    input  logic                sys_rst_n,
    input  logic [10:0]         pixel_xpos,
    input  logic [10:0]         pixel_ypos,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic [3*CW-1:0]     pixel_data
);
    localparam logic [10:0] X0  = 11'(WIN_X0);
    localparam logic [10:0] X1  = 11'(WIN_X1);
    localparam logic [10:0] Y0  = 11'(WIN_Y0);
    localparam logic [10:0] Y1  = 11'(WIN_Y1);
    localparam logic [10:0] XC  = 11'((WIN_X0 + WIN_X1) / 2);
    localparam logic [10:0] YC  = 11'((WIN_Y0 + WIN_Y1) / 2);
    localparam logic [10:0] HD  = 11'(H_DISP);
    localparam logic [10:0] VD  = 11'(V_DISP);
    localparam logic [10:0] HL  = 11'(H_DISP - 1);
    localparam logic [10:0] VL  = 11'(V_DISP - 1);
    localparam logic [10:0] GXM = 11'(GRID_X - 1);
    localparam logic [10:0] GYM = 11'(GRID_Y - 1);
    localparam logic [31:0] SPAN_X = 32'(WIN_X1 - WIN_X0);
    localparam logic [31:0] SPAN_Y = 32'(WIN_Y1 - WIN_Y0);
    localparam logic [CW-1:0] FULL = {CW{1'b1}};
    localparam logic [CW-1:0] NONE = {CW{1'b0}};
    localparam logic [CW-1:0] LVL1 = CW'(1);
    localparam logic [3*CW-1:0] C_GREEN  = {NONE, FULL, NONE};
    localparam logic [3*CW-1:0] C_YELLOW = {FULL, FULL, NONE};
    localparam logic [3*CW-1:0] C_WHITE  = {FULL, FULL, FULL};
    localparam logic [3*CW-1:0] C_DIM    = {NONE, LVL1, NONE};

    logic [SAMPLE_W-1:0] mem [2][2**AW];
    logic [SAMPLE_W-1:0] smp;
    logic                front, pend, fv1, first1;
    logic [1:0]          vld;
    logic [10:0]         x1, y1, row1, rowp, gx, gy, row_c, lo, hi;
    logic                sp, swap, in_win, border, axis, grid, trace;
    logic [3*CW-1:0]     pix_c;

    assign smp   = mem[front][AW'(pixel_xpos - X0)];
    assign row_c = (32'(smp) > SPAN_Y) ? Y0 : Y1 - 11'(smp);
    assign sp    = (pixel_xpos == HL) && (pixel_ypos == VL);
    assign swap  = sp && (pend || swap_req);

    // Writes always target the bank that is back during this cycle, even at the swap point.
    always_ff @(posedge pixel_clk)
        if (wr_en && 32'(wr_addr) <= SPAN_X)
            mem[~front][wr_addr] <= wr_data;

    always_ff @(posedge pixel_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            front    <= 1'b0;
            pend     <= 1'b0;
            vld      <= 2'b00;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= swap;
            pend     <= !sp && (pend || swap_req);
            if (swap) begin
                front      <= ~front;
                vld[~front] <= 1'b1;
            end
        end

    // Grid phase counters assume a raster scan: x advances every cycle, y is sampled at column 0.
    always_ff @(posedge pixel_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            x1     <= '0;
            y1     <= '0;
            row1   <= '0;
            rowp   <= '0;
            gx     <= '0;
            gy     <= '0;
            first1 <= 1'b0;
            fv1    <= 1'b0;
        end else begin
            x1     <= pixel_xpos;
            y1     <= pixel_ypos;
            row1   <= row_c;
            rowp   <= row1;
            first1 <= pixel_xpos == X0;
            fv1    <= vld[front];
            gx     <= (pixel_xpos == X0 || gx == GXM) ? '0 : gx + 11'd1;
            if (pixel_xpos == 11'd0)
                gy <= (pixel_ypos == Y0 || gy == GYM) ? '0 : gy + 11'd1;
        end

    assign lo     = (rowp < row1) ? rowp : row1;
    assign hi     = (rowp < row1) ? row1 : rowp;
    assign in_win = x1 >= X0 && x1 <= X1 && y1 >= Y0 && y1 <= Y1 && x1 < HD && y1 < VD;
    assign border = x1 == X0 || x1 == X1 || y1 == Y0 || y1 == Y1;
    assign trace  = fv1 && (first1 ? y1 == row1 : (y1 >= lo && y1 <= hi));
    assign axis   = x1 == XC || y1 == YC;
    assign grid   = (gx == 11'd0 && y1[0]) || (gy == 11'd0 && x1[0]);
    assign pix_c  = !in_win ? '0 : border ? C_GREEN : trace ? C_YELLOW :
                    axis ? C_WHITE : grid ? C_DIM : '0;

    always_ff @(posedge pixel_clk or negedge sys_rst_n)
        if (!sys_rst_n)
            pixel_data <= '0;
        else
            pixel_data <= pix_c;
endmodule

// File: doc/vga_scope_display.md
VGA_SCOPE_DISPLAY -- requirements
Module: vga_scope_display

Interface
REQ-001 SHALL have parameter H_DISP, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 720, active lines per frame.
REQ-003 SHALL have parameters WIN_X0/WIN_X1/WIN_Y0/WIN_Y1, defaults 139/1140/48/624, inclusive plot-window bounds.
REQ-004 SHALL have parameters GRID_X/GRID_Y, defaults 64/32, graticule pitch in pixels relative to WIN_X0/WIN_Y0.
REQ-005 SHALL have parameter CW, default 2, colour bits per channel; SAMPLE_W, default 10, sample width; AW, default 10, buffer address width.
REQ-006 SHALL have ports: pixel_clk input 1, pixel clock; sys_rst_n input 1, reset.
REQ-007 Clocking SHALL be one clock, pixel_clk; reset sys_rst_n SHALL be asynchronous and active-low.
REQ-008 SHALL have pixel_xpos input 11, current column; pixel_ypos input 11, current row.
REQ-009 SHALL have wr_en input 1, wr_addr input AW, wr_data input SAMPLE_W: sample write port.
REQ-010 SHALL have swap_req input 1, request bank swap; swap_ack output 1, one-cycle pulse when swap occurs.
REQ-011 SHALL have pixel_data output 3*CW, RGB pixel, R in MSBs.

Function
REQ-012 SHALL hold two sample banks of 2^AW x SAMPLE_W; front bank read for display, back bank written by wr_en.
REQ-013 Sample at address a SHALL map to column WIN_X0+a; writes with WIN_X0+wr_addr > WIN_X1 SHALL be ignored.
REQ-014 swap_req high for one cycle SHALL set a pending flag; further requests while pending SHALL merge.
REQ-015 Swap point SHALL be the cycle with pixel_xpos==H_DISP-1 and pixel_ypos==V_DISP-1; if pending (or swap_req high that cycle) banks exchange, pending clears, swap_ack pulses the next cycle.
REQ-016 A write in the swap-point cycle SHALL land in the pre-swap back bank.
REQ-017 Each bank SHALL carry a valid flag set on swap into front; trace SHALL be suppressed while front bank invalid.
REQ-018 pixel_data SHALL have fixed latency of 2 pixel_clk cycles from pixel_xpos/pixel_ypos.
REQ-019 Grid phase SHALL use x/y modulo counters (no dividers), cleared when coordinate equals WIN_X0/WIN_Y0, wrapping at GRID_X-1/GRID_Y-1.
REQ-020 Trace row SHALL be WIN_Y1-s, clipped to WIN_Y0 when s > WIN_Y1-WIN_Y0.
REQ-021 Trace SHALL fill vertically between previous-column row and current row inclusive; first window column draws its own row only.
REQ-022 Colour priority: outside window -> black; border (window edge) -> full green; trace -> yellow (R,G full); axis (x==(WIN_X0+WIN_X1)/2 or y==(WIN_Y0+WIN_Y1)/2) -> white; grid column with ypos odd, or grid row with xpos odd -> green level 1; else black.
REQ-023 Coordinates >= H_DISP or >= V_DISP SHALL yield black.

Reset
REQ-024 On sys_rst_n low, pixel_data SHALL be 0, swap_ack 0, pending 0, front bank index 0, both valid flags 0, counters 0.
REQ-025 Reset mid-frame SHALL take effect immediately; output valid 2 cycles after release with coordinates supplied; buffer contents are not reset.

Verification
REQ-026 Reset, scan full frame, no swap -> only border, axes, dotted grid; pixel at (640,336) white, (139,48) green, (203,49) level-1 green, (0,0) black.
REQ-027 Write all samples 100, swap_req, scan to swap point -> swap_ack one cycle after (1279,719); next frame row 524 yellow across window.
REQ-028 Samples 0 at a=10, 200 at a=11 -> column 150 yellow from row 424 to 624 inclusive.
REQ-029 Sample 1000 -> clipped, row 48 shows border green (priority) at that column.
REQ-030 swap_req asserted exactly at swap-point cycle plus wr_en same cycle -> swap happens, written sample appears in next frame's displayed bank.
REQ-031 Assert sys_rst_n low during active scan -> pixel_data 0 that cycle asynchronously; after release front bank invalid, no trace drawn.
